// File: rtl/fan_pkg.sv
// Shared types and helpers for the board fan PWM controller.
package fan_pkg;

  // Controller states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_KICK   = 2'd1,
    ST_RAMP   = 2'd2,
    ST_STEADY = 2'd3
  } fan_state_e;

  // Compare value for a 4-bit setting: ceil(period * s / 15).
  // Evaluated at 32 bits, so the product never overflows for any sane period;
  // s = 0 maps to 0, s = 15 maps to period, and any nonzero s maps to >= 1.
  function automatic logic [31:0] fan_duty_from_setting(input logic [31:0] period,
                                                        input logic [3:0]  s);
    logic [31:0] prod;
    prod = period * {28'd0, s};
    return (prod + 32'd14) / 32'd15;
  endfunction

endpackage

// File: rtl/fan_debounce.sv
// Two-flop synchroniser followed by a stability counter. A new value is
// accepted only after it has been seen unchanged for Cycles clocks, giving
// a total latency of 2 + Cycles clocks from input change to q_o.
module fan_debounce #(
  parameter int Width  = 4,
  parameter int Cycles = 50_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  localparam int CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Cycles - 1);

  logic [Width-1:0] r_sync1;
  logic [Width-1:0] r_cand;   // second synchroniser flop doubles as the candidate
  logic [CntW-1:0]  r_cnt;
  logic [Width-1:0] r_q;

  // Synchronise, restart the count on any change, accept once stable long enough.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
    end else begin
      r_sync1 <= d_i;
      r_cand  <= r_sync1;
      if (r_sync1 != r_cand) begin
        r_cnt <= '0;
      end else if (r_cnt == LastCnt) begin
        r_q <= r_cand;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/fan_pwm_ctrl.sv
// Board fan controller: debounced 4-bit setting in, glitch-free PWM out.
// Spin-up from standstill gets a full-duty kick, then the duty ramps one
// count at a time toward the target; the applied compare value only changes
// at a PWM period boundary.
module fan_pwm_ctrl
  import fan_pkg::*;
#(
  parameter  int ClkFreqHz      = 50_000_000,
  parameter  int PwmFreqHz      = 25_000,
  parameter  int DebounceCycles = 50_000,
  parameter  int KickCycles     = 25_000_000,
  parameter  int RampDivCycles  = 500,
  localparam int PwmPeriod      = ClkFreqHz / PwmFreqHz,
  localparam int CntW           = $clog2(PwmPeriod + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [3:0]      pwm_setting_i,
  output logic            fan_pwm_o,
  output logic [CntW-1:0] duty_o,
  output logic [1:0]      state_o
);

  localparam int KickW = $clog2(KickCycles + 1);
  localparam int DivW  = $clog2(RampDivCycles + 1);

  localparam logic [CntW-1:0]  PeriodLast = CntW'(PwmPeriod - 1);
  localparam logic [CntW-1:0]  PeriodFull = CntW'(PwmPeriod);
  localparam logic [KickW-1:0] KickLast   = KickW'(KickCycles - 1);
  localparam logic [DivW-1:0]  DivLast    = DivW'(RampDivCycles - 1);

  logic [3:0]      w_setting_q;
  logic [CntW-1:0] w_tgt;

  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  r_duty;
  logic             r_pwm;
  fan_state_e       r_state;
  logic [CntW-1:0]  r_cur;
  logic [KickW-1:0] r_kick_cnt;
  logic [DivW-1:0]  r_div;

  fan_debounce #(
    .Width  (4),
    .Cycles (DebounceCycles)
  ) u_debounce (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pwm_setting_i),
    .q_o    (w_setting_q)
  );

  // Target compare value; the upper bits are always zero for s <= 15.
  assign w_tgt = CntW'(fan_duty_from_setting(32'(PwmPeriod), w_setting_q));

  // Free-running period counter; the duty request is applied only at wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      if (r_cnt == PeriodLast) begin
        r_cnt  <= '0;
        r_duty <= r_cur;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
      r_pwm <= (r_cnt < r_duty);
    end
  end

  // Kick / ramp / steady state machine producing the internal duty request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_OFF;
      r_cur      <= '0;
      r_kick_cnt <= '0;
      r_div      <= '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_cur <= '0;
          if (w_tgt != '0) begin
            r_state    <= ST_KICK;
            r_kick_cnt <= '0;
            r_cur      <= PeriodFull;
          end
        end
        ST_KICK: begin
          // Setting changes are deliberately ignored until the kick completes.
          if (r_kick_cnt == KickLast) begin
            r_state <= ST_RAMP;
            r_div   <= '0;
          end else begin
            r_kick_cnt <= r_kick_cnt + KickW'(1);
          end
        end
        ST_RAMP: begin
          if (r_cur == w_tgt) begin
            r_state <= (w_tgt != '0) ? ST_STEADY : ST_OFF;
          end else if (r_div == DivLast) begin
            r_div <= '0;
            r_cur <= (r_cur < w_tgt) ? r_cur + CntW'(1) : r_cur - CntW'(1);
          end else begin
            r_div <= r_div + DivW'(1);
          end
        end
        ST_STEADY: begin
          if (w_tgt != r_cur) begin
            r_state <= ST_RAMP;
            r_div   <= '0;
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign fan_pwm_o = r_pwm;
  assign duty_o    = r_duty;
  assign state_o   = r_state;

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// Scoreboard bench for fan_pwm_ctrl with scaled-down timing
// (PwmPeriod = 10, debounce 4, kick 20, ramp step every 2 clocks).
// Stimulus pushes the expected {cycle, state, duty} output changes; a monitor
// pops one entry whenever state_o or duty_o changes and also checks the PWM
// waveform against the period phase and applied duty every clock.
module tb_fan_pwm_ctrl;

  localparam int Period = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] setting;
  wire        fan;
  wire  [3:0] duty;
  wire  [1:0] state;

  fan_pwm_ctrl #(
    .ClkFreqHz      (1000),
    .PwmFreqHz      (100),
    .DebounceCycles (4),
    .KickCycles     (20),
    .RampDivCycles  (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pwm_setting_i (setting),
    .fan_pwm_o     (fan),
    .duty_o        (duty),
    .state_o       (state)
  );

  always #5 clk = ~clk;

  // Absolute edge count and the bench's own view of the PWM period phase.
  int cyc = 0;
  int ph  = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= 0;
    else        ph <= (ph == Period - 1) ? 0 : ph + 1;
  end

  typedef struct {
    int c;
    int s;
    int d;
  } ev_t;
  ev_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int s, input int d);
    ev_t e;
    e.c = c; e.s = s; e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard pop on output change, plus per-cycle PWM shape check.
  int last_st = 0, last_du = 0, prev_ph = 0, prev_du = 0;
  always @(negedge clk) begin
    if (int'(state) != last_st || int'(duty) != last_du) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_change: got state %0d duty %0d at cycle %0d, expected no change",
                 state, duty, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_cycle", cyc, e.c);
        check("ev_state", int'(state), e.s);
        check("ev_duty", int'(duty), e.d);
      end
      last_st = int'(state);
      last_du = int'(duty);
    end
    if (!rst_n) begin
      check("pwm_in_reset", int'(fan), 0);
      prev_ph = 0;
      prev_du = 0;
    end else begin
      check("pwm_pattern", int'(fan), int'(prev_ph < prev_du));
      prev_ph = ph;
      prev_du = int'(duty);
    end
  end

  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ph != p && n < 50);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("events_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(fan);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, hi;
    rst_n   = 1'b0;
    setting = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state and idle with setting 0.
    check("reset_state", int'(state), 0);
    check("reset_duty", int'(duty), 0);
    check("reset_pwm", int'(fan), 0);
    repeat (30) @(posedge clk);
    #1;
    check("idle_state", int'(state), 0);
    check("idle_duty", int'(duty), 0);

    // 0 -> 8: kick, ramp 10 -> 6, steady with 6/10 high.
    wait_phase(0); a = cyc; setting = 4'd8;
    push(a + 7, 1, 0);  push(a + 10, 1, 10); push(a + 27, 2, 10);
    push(a + 30, 2, 9); push(a + 36, 3, 9);  push(a + 40, 3, 6);
    drain(80);
    count_high(Period, hi);
    check("high_s8", hi, 6);

    // Setting chatters 15 <-> 8 every 2 clocks: never accepted.
    for (int i = 0; i < 8; i++) begin
      setting = (i % 2 == 0) ? 4'd15 : 4'd8;
      repeat (2) @(posedge clk);
      #1;
    end
    repeat (12) @(posedge clk);
    #1;
    check("chatter_state", int'(state), 3);
    check("chatter_duty", int'(duty), 6);

    // Steady 6 -> 15: ramp up to full duty.
    wait_phase(0); a = cyc; setting = 4'd15;
    push(a + 7, 2, 6); push(a + 10, 2, 7); push(a + 16, 3, 7); push(a + 20, 3, 10);
    drain(60);
    count_high(Period, hi);
    check("high_s15", hi, 10);

    // 15 -> 0: ramp 10 -> 0, then OFF with a constantly low output.
    wait_phase(0); a = cyc; setting = 4'd0;
    push(a + 7, 2, 10); push(a + 10, 2, 9); push(a + 20, 2, 4);
    push(a + 28, 0, 4); push(a + 30, 0, 0);
    drain(60);
    count_high(2 * Period, hi);
    check("high_off", hi, 0);

    // s = 1 from OFF: kick, then ramp all the way down to compare value 1.
    wait_phase(0); a = cyc; setting = 4'd1;
    push(a + 7, 1, 0);  push(a + 10, 1, 10); push(a + 27, 2, 10); push(a + 30, 2, 9);
    push(a + 40, 2, 4); push(a + 46, 3, 4);  push(a + 50, 3, 1);
    drain(80);
    count_high(Period, hi);
    check("high_s1", hi, 1);

    // Mid-period change 1 -> 5 (target 4): duty_o moves only at the next wrap.
    wait_phase(5); a = cyc; setting = 4'd5;
    push(a + 7, 2, 1); push(a + 14, 3, 1); push(a + 15, 3, 4);
    drain(40);
    count_high(Period, hi);
    check("high_s5", hi, 4);

    // Reset in the middle of a ramp 4 -> 10, then a fresh kick after release.
    wait_phase(0); a = cyc; setting = 4'd15;
    push(a + 7, 2, 4); push(a + 10, 2, 5); push(a + 12, 0, 0);
    repeat (12) @(posedge clk);
    #1;
    check("pre_reset_state", int'(state), 2);
    rst_n = 1'b0;
    #1;
    check("async_reset_state", int'(state), 0);
    check("async_reset_duty", int'(duty), 0);
    check("async_reset_pwm", int'(fan), 0);
    repeat (3) @(posedge clk);
    #1; a = cyc; rst_n = 1'b1;
    push(a + 7, 1, 0); push(a + 10, 1, 10); push(a + 27, 2, 10); push(a + 28, 3, 10);
    drain(60);
    count_high(Period, hi);
    check("high_after_reset", hi, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
